// File: rtl/spram8_pkg.sv
// spram8_pkg: shared widths and types for the 128 KiB byte-wide single-port RAM.
package spram8_pkg;
    localparam int ASZ     = 17;
    localparam int DSZ     = 8;
    localparam int BANK_AW = 14;
    localparam int NBANK   = 4;
    typedef logic [16:0] addr_t;
    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word_t;
endpackage

// File: rtl/spram16_16k.sv
// spram16_16k: 16K x 16 bank, 2-bit byte write mask, registered read (no read on write cycles).
// Define SPRAM8_ICE40_EN to map the bank onto an SB_SPRAM256KA primitive.
module spram16_16k
    import spram8_pkg::*;
(
    input  logic               clk,
    input  logic [BANK_AW-1:0] addr,
    input  logic [1:0]         wm,
    input  logic [15:0]        din,
    output logic [15:0]        dout
);
`ifdef SPRAM8_ICE40_EN
    SB_SPRAM256KA u_spram (
        .ADDRESS    (addr),
        .DATAIN     (din),
        .MASKWREN   ({wm[1], wm[1], wm[0], wm[0]}),
        .WREN       (|wm),
        .CHIPSELECT (1'b1),
        .CLOCK      (clk),
        .STANDBY    (1'b0),
        .SLEEP      (1'b0),
        .POWEROFF   (1'b1),
        .DATAOUT    (dout)
    );
`else
    logic [15:0] mem [0:(1<<BANK_AW)-1];

    always_ff @(posedge clk) begin
        if (wm[0]) mem[addr][7:0] <= din[7:0];
        if (wm[1]) mem[addr][15:8] <= din[15:8];
        if (wm == 2'b00) dout <= mem[addr];
    end
`endif
endmodule

// File: rtl/spram8_128k.sv
// spram8_128k: 128 KiB byte RAM from four 16K x 16 banks with a registered bank/lane output mux.
// Bank primitive selection is controlled by SPRAM8_ICE40_EN inside spram16_16k.
module spram8_128k
    import spram8_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [ASZ-1:0] ai,
    input  logic [DSZ-1:0] vi,
    output logic [DSZ-1:0] vo
);
    word_t       rd [NBANK];
    logic [1:0]  bank_q;
    logic        lane_q;
    logic        rd_q;
    byte_t       hold;
    word_t       sel;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        spram16_16k u_bank (
            .clk  (clk),
            .addr (ai[BANK_AW:1]),
            .wm   ((we && ai[16:15] == 2'(b)) ? (ai[0] ? 2'b10 : 2'b01) : 2'b00),
            .din  ({vi, vi}),
            .dout (rd[b])
        );
    end

    // Unwritten banks may still clock a read during a write cycle, so vo is held locally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
            lane_q <= 1'b0;
            rd_q   <= 1'b0;
            hold   <= '0;
        end else begin
            hold <= vo;
            rd_q <= !we;
            if (!we) begin
                bank_q <= ai[16:15];
                lane_q <= ai[0];
            end
        end
    end

    always_comb begin
        sel = rd[bank_q];
        vo  = rd_q ? (lane_q ? sel[15:8] : sel[7:0]) : hold;
    end
endmodule

// File: tb/tb_spram8_128k.sv
// tb_spram8_128k: directed plus randomized checks of spram8_128k against a sparse byte-array model.
module tb_spram8_128k;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [16:0] ai = '0;
    logic [7:0]  vi = '0;
    logic [7:0]  vo;

    logic [7:0]  model [int];
    logic [7:0]  exp_vo = 8'h00;
    logic        known = 1'b1;
    int          nvec = 0;
    int          errs = 0;

    spram8_128k dut (.clk(clk), .rst_n(rst_n), .we(we), .ai(ai), .vi(vi), .vo(vo));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic op(input string tag, input logic w, input int a, input logic [7:0] d);
        we = w;
        ai = 17'(a);
        vi = d;
        #2;
        if (known) chk({tag, "_pre"}, vo, exp_vo);
        @(posedge clk);
        #1;
        if (w) model[a] = d;
        else begin
            known = model.exists(a);
            if (known) exp_vo = model[a];
        end
        if (known) chk(tag, vo, exp_vo);
        @(negedge clk);
    endtask

    task automatic rd_const(input string tag, input int a, input logic [7:0] v);
        op(tag, 1'b0, a, 8'h00);
        chk({tag, "_const"}, vo, v);
    endtask

    initial begin
        #1;
        chk("reset_vo", vo, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        rd_const("reset_idle", 0, 8'h00);

        for (int i = 0; i <= 16; i++) op("fill_wr", 1'b1, i, 8'(i));
        for (int i = 0; i <= 20; i++) op("fill_rd", 1'b0, i, 8'h00);

        for (int i = 0; i <= 16; i++)
            op("walk_wr", 1'b1, (1 << i) | (i & 3), (i < 8) ? 8'(1 << i) : 8'(8'hFF >> (i - 8)));
        for (int i = 0; i <= 16; i++) op("walk_rd", 1'b0, (1 << i) | (i & 3), 8'h00);
        rd_const("walk_1", 'h00001, 8'h01);
        rd_const("walk_3", 'h00003, 8'h02);
        rd_const("walk_100", 'h00100, 8'hFF);
        rd_const("walk_10000", 'h10000, 8'h00);

        for (int i = 0; i <= 16; i++) op("high_wr", 1'b1, 'h1FFFF - i, 8'(i));
        for (int i = 0; i <= 16; i++) op("high_rd", 1'b0, 'h1FFFF - i, 8'h00);
        rd_const("high_1ffff", 'h1FFFF, 8'h00);
        rd_const("high_1fffe", 'h1FFFE, 8'h01);
        rd_const("high_1ffef", 'h1FFEF, 8'h10);
        rd_const("low_kept_0", 'h00000, 8'h00);
        rd_const("low_kept_5", 'h00005, 8'h05);

        op("lane_wr", 1'b1, 'h00A, 8'h5A);
        op("lane_wr", 1'b1, 'h00B, 8'hA5);
        rd_const("lane_a", 'h00A, 8'h5A);
        rd_const("lane_b", 'h00B, 8'hA5);
        op("hold_wr", 1'b1, 'h00C, 8'h3C);
        chk("hold_after_wr", vo, 8'hA5);

        op("rst_wr", 1'b1, 'h1234, 8'h77);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async", vo, 8'h00);
        exp_vo = 8'h00;
        known = 1'b1;
        @(negedge clk);
        chk("rst_held", vo, 8'h00);
        rst_n = 1'b1;
        rd_const("rst_after", 'h1234, 8'h77);

        for (int n = 0; n < 3000; n++) begin
            int a;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'h1FFFF))
                                            : int'($urandom_range(0, 3) << 15) | int'($urandom_range(0, 31));
            op("rand", $urandom_range(0, 9) < 4, a, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
